// File: rtl/fsm_input_arbiter.sv
// rtl/fsm_input_arbiter.sv - round-robin arbiter sharing the FSM (i,j) inputs between two requesters
//
// Ports:
//   clk        clock, all logic on posedge
//   rstn       synchronous reset, active high (1 = reset)
//   req0/req1  requester wants the FSM inputs, held for the whole burst
//   len0/len1  burst length in cycles, sampled at the grant decision (0 acts as 1)
//   ij0/ij1    requester stimulus {i,j}, passed through while granted
//   gnt0/gnt1  requester owns the FSM inputs this cycle
//   i, j       FSM inputs
//   busy       high while granting or in the idle gap
//   done       pulse on the last granted cycle of a completed burst
//   abort      pulse when the owner drops its request mid-burst
module fsm_input_arbiter #(
  parameter int LEN_W      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0,
  input  logic [LEN_W-1:0] len0,
  input  logic [1:0]       ij0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len1,
  input  logic [1:0]       ij1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             i,
  output logic             j,
  output logic             busy,
  output logic             done,
  output logic             abort
);

  localparam int GW       = $clog2(GAP_CYCLES + 2);
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // With no gap configured a finished burst returns straight to arbitration.
  localparam state_t AFTER_BURST = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_t           state, state_nxt;
  logic             owner, owner_nxt;
  logic             last_owner, last_owner_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [GW-1:0]    gap_cnt, gap_cnt_nxt;

  logic             pick;
  logic [LEN_W-1:0] pick_len;
  logic             owner_req;
  logic [1:0]       owner_ij;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cnt        <= '0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      cnt        <= cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    cnt_nxt        = cnt;
    gap_cnt_nxt    = gap_cnt;
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    i              = 1'b0;
    j              = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    abort          = 1'b0;

    // Contention goes to whoever did not own the previous burst.
    if (req0 && req1) begin
      pick = ~last_owner;
    end else begin
      pick = req1;
    end
    pick_len  = pick ? len1 : len0;
    owner_req = owner ? req1 : req0;
    owner_ij  = owner ? ij1 : ij0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt = GRANT;
          owner_nxt = pick;
          cnt_nxt   = (pick_len == '0) ? '0 : pick_len - LEN_W'(1);
        end
      end
      GRANT: begin
        busy   = 1'b1;
        gnt0   = ~owner;
        gnt1   = owner;
        {i, j} = owner_ij;
        // A dropped request takes precedence over completion on the last cycle.
        if (!owner_req) begin
          abort          = 1'b1;
          last_owner_nxt = owner;
          state_nxt      = AFTER_BURST;
          gap_cnt_nxt    = GW'(GAP_LOAD);
        end else if (cnt == '0) begin
          done           = 1'b1;
          last_owner_nxt = owner;
          state_nxt      = AFTER_BURST;
          gap_cnt_nxt    = GW'(GAP_LOAD);
        end else begin
          cnt_nxt = cnt - LEN_W'(1);
        end
      end
      GAP: begin
        busy = 1'b1;
        if (gap_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - GW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Outputs stay quiet throughout reset, so an interrupted burst never pulses.
    if (rstn) begin
      gnt0  = 1'b0;
      gnt1  = 1'b0;
      i     = 1'b0;
      j     = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      abort = 1'b0;
    end
  end

endmodule

// File: tb/tb_fsm_input_arbiter.sv
// tb/tb_fsm_input_arbiter.sv - self-checking bench for fsm_input_arbiter (gap 1 and gap 0 instances)
module tb_fsm_input_arbiter;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] len0 = 4'd0, len1 = 4'd0;
  logic [1:0] ij0 = 2'd0, ij1 = 2'd0;

  logic a_gnt0, a_gnt1, a_i, a_j, a_busy, a_done, a_abort;
  logic b_gnt0, b_gnt1, b_i, b_j, b_busy, b_done, b_abort;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t0;

  // Sampled outputs per instance per cycle: {gnt0,gnt1,i,j,busy,done,abort}
  logic [6:0] hist [2][4096];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fsm_input_arbiter #(.LEN_W(4), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rstn(rstn),
    .req0(req0), .len0(len0), .ij0(ij0),
    .req1(req1), .len1(len1), .ij1(ij1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .i(a_i), .j(a_j),
    .busy(a_busy), .done(a_done), .abort(a_abort)
  );

  fsm_input_arbiter #(.LEN_W(4), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rstn(rstn),
    .req0(req0), .len0(len0), .ij0(ij0),
    .req1(req1), .len1(len1), .ij1(ij1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .i(b_i), .j(b_j),
    .busy(b_busy), .done(b_done), .abort(b_abort)
  );

  // Behavioural model: mode 0 = waiting, 1 = in a burst, 2 = gap.
  int m_mode [2];
  int m_own  [2];
  int m_last [2];
  int m_used [2];
  int m_len  [2];
  int m_gap  [2];
  int gapv   [2];

  initial begin
    gapv[0] = 1;
    gapv[1] = 0;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_own[k] = 0; m_last[k] = 1;
      m_used[k] = 0; m_len[k] = 1; m_gap[k] = 0;
    end
  end

  logic [6:0] exp_o, got_o;
  logic       own_req;
  logic [1:0] own_ij;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_o = '0;
      got_o = (k == 0) ? {a_gnt0, a_gnt1, a_i, a_j, a_busy, a_done, a_abort}
                       : {b_gnt0, b_gnt1, b_i, b_j, b_busy, b_done, b_abort};
      if (rstn) begin
        m_mode[k] = 0;
        m_last[k] = 1;
      end else if (m_mode[k] == 0) begin
        if (req0 || req1) begin
          if (req0 && req1) m_own[k] = 1 - m_last[k];
          else              m_own[k] = req1 ? 1 : 0;
          m_len[k]  = (m_own[k] == 1) ? int'(len1) : int'(len0);
          if (m_len[k] == 0) m_len[k] = 1;
          m_used[k] = 0;
          m_mode[k] = 1;
        end
      end else if (m_mode[k] == 1) begin
        own_req  = (m_own[k] == 1) ? req1 : req0;
        own_ij   = (m_own[k] == 1) ? ij1 : ij0;
        exp_o[6] = (m_own[k] == 0);
        exp_o[5] = (m_own[k] == 1);
        exp_o[4:3] = own_ij;
        exp_o[2] = 1'b1;
        m_used[k] = m_used[k] + 1;
        if (!own_req)                  exp_o[0] = 1'b1;
        else if (m_used[k] == m_len[k]) exp_o[1] = 1'b1;
        if (exp_o[0] || exp_o[1]) begin
          m_last[k] = m_own[k];
          if (gapv[k] > 0) begin
            m_mode[k] = 2;
            m_gap[k]  = gapv[k];
          end else begin
            m_mode[k] = 0;
          end
        end
      end else begin
        exp_o[2] = 1'b1;
        m_gap[k] = m_gap[k] - 1;
        if (m_gap[k] == 0) m_mode[k] = 0;
      end
      n_checks++;
      if (got_o === exp_o) n_pass++;
      else $display("FAIL model_cmp inst%0d cycle %0d: got %b expected %b", k, cyc, got_o, exp_o);
      if (cyc < 4096) hist[k][cyc] = got_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic chk_vec(input string name, input logic [6:0] act, input logic [6:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, expv);
  endtask

  task automatic chk_trace(input string name, input int inst, input int bitpos,
                           input int start, input int n, input logic [31:0] expv);
    logic [31:0] act;
    act = '0;
    for (int c = 0; c < n; c++) act[c] = hist[inst][start + c][bitpos];
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got trace %h expected %h", name, act, expv);
  endtask

  initial begin
    // 1: single burst of 4 from requester 0
    do_reset();
    chk_vec("reset_a", hist[0][cyc - 1], 7'd0);
    chk_vec("reset_b", hist[1][cyc - 1], 7'd0);
    rstn = 1'b0; req0 = 1'b1; len0 = 4'd4; ij0 = 2'b10; req1 = 1'b0;
    t0 = cyc;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 4) req0 = 1'b0;
    end
    chk_trace("t1_gnt0", 0, 6, t0, 8, 32'h1E);
    chk_trace("t1_i",    0, 4, t0, 8, 32'h1E);
    chk_trace("t1_j",    0, 3, t0, 8, 32'h00);
    chk_trace("t1_done", 0, 1, t0, 8, 32'h10);
    chk_trace("t1_busy", 0, 2, t0, 8, 32'h3E);
    chk_trace("t1_busy_nogap", 1, 2, t0, 8, 32'h1E);

    // 2: both requesting, alternating bursts of 2 and 3
    do_reset();
    rstn = 1'b0; req0 = 1'b1; req1 = 1'b1; len0 = 4'd2; len1 = 4'd3;
    t0 = cyc;
    repeat (17) tick();
    chk_trace("t2_gnt0", 0, 6, t0, 17, 32'h0C06);
    chk_trace("t2_gnt1", 0, 5, t0, 17, 32'h1C0E0);

    // 3: zero length behaves as one cycle
    do_reset();
    rstn = 1'b0; req0 = 1'b0; req1 = 1'b1; len1 = 4'd0; ij1 = 2'b01;
    t0 = cyc;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 1) req1 = 1'b0;
    end
    chk_trace("t3_gnt1", 0, 5, t0, 4, 32'h2);
    chk_trace("t3_done", 0, 1, t0, 4, 32'h2);
    chk_trace("t3_j",    0, 3, t0, 4, 32'h2);
    chk_trace("t3_i",    0, 4, t0, 4, 32'h0);

    // 4: owner drops mid-burst, pending requester takes over
    do_reset();
    rstn = 1'b0; req0 = 1'b1; len0 = 4'd8; req1 = 1'b1; len1 = 4'd2;
    t0 = cyc;
    for (int c = 0; c < 9; c++) begin
      tick();
      if (c == 2) req0 = 1'b0;
    end
    chk_trace("t4_gnt0",  0, 6, t0, 9, 32'h0E);
    chk_trace("t4_abort", 0, 0, t0, 9, 32'h08);
    chk_trace("t4_done",  0, 1, t0, 9, 32'h80);
    chk_trace("t4_gnt1",  0, 5, t0, 9, 32'hC0);

    // 5: zero gap, repeated bursts of 2
    do_reset();
    rstn = 1'b0; req0 = 1'b1; len0 = 4'd2; req1 = 1'b0;
    t0 = cyc;
    repeat (7) tick();
    chk_trace("t5_gnt0_nogap", 1, 6, t0, 7, 32'h36);

    // 6: reset during a burst
    do_reset();
    rstn = 1'b0; req0 = 1'b1; len0 = 4'd5; req1 = 1'b1; len1 = 4'd3;
    t0 = cyc;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 1) rstn = 1'b1;
      if (c == 2) rstn = 1'b0;
    end
    chk_trace("t6_gnt0",  0, 6, t0, 5, 32'h12);
    chk_trace("t6_gnt1",  0, 5, t0, 5, 32'h00);
    chk_trace("t6_done",  0, 1, t0, 5, 32'h00);
    chk_trace("t6_abort", 0, 0, t0, 5, 32'h00);
    chk_vec("t6_in_reset", hist[0][t0 + 2], 7'd0);
    chk_vec("t6_after_reset", hist[0][t0 + 3], 7'd0);

    // Random phase, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) req0 = ~req0;
      if ($urandom_range(0, 7) == 0) req1 = ~req1;
      if ($urandom_range(0, 3) == 0) len0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) len1 = 4'($urandom_range(0, 15));
      ij0  = 2'($urandom_range(0, 3));
      ij1  = 2'($urandom_range(0, 3));
      rstn = ($urandom_range(0, 199) == 0);
      tick();
    end
    rstn = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
